// File: rtl/control_unit.sv
// Multi-cycle control unit for an 8-bit accumulator-style core.
// It sequences fetch, decode, execute and operand steps, and drives the program memory and the register-file control signals.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] mem_data,
  output logic [7:0] mem_addr,
  output logic [2:0] alu_sel,
  output logic [1:0] rf_raddr_a,
  output logic [1:0] rf_raddr_b,
  output logic [1:0] rf_waddr,
  output logic       rf_we,
  output logic       wb_sel,
  output logic [7:0] imm_data,
  output logic       halted
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    OPERAND = 3'd3,
    IMM     = 3'd4,
    HALT    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MOV = 3'b100,
    OP_LDI = 3'b101,
    OP_JMP = 3'b110,
    OP_HLT = 3'b111
  } opcode_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  // ir bit 0 carries no meaning, so only bits 7:1 are stored
  logic [7:1] ir_q, ir_d;
  logic       we_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    alu_sel  = '0;
    we_raw   = 1'b0;
    wb_sel   = 1'b0;
    imm_data = '0;

    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        ir_d = mem_data[7:1];
        pc_d = pc_q + 8'd1;
        case (opcode_e'(mem_data[7:5]))
          OP_LDI, OP_JMP: state_d = OPERAND;
          OP_HLT:         state_d = HALT;
          default:        state_d = EXEC;
        endcase
      end
      EXEC: begin
        alu_sel = ir_q[7:5];
        we_raw  = 1'b1;
        state_d = FETCH;
      end
      OPERAND: state_d = IMM;
      IMM: begin
        if (opcode_e'(ir_q[7:5]) == OP_LDI) begin
          imm_data = mem_data;
          wb_sel   = 1'b1;
          we_raw   = 1'b1;
          pc_d     = pc_q + 8'd1;
        end else begin
          pc_d = mem_data;
        end
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

    // A stall freezes all architectural state; the step then replays once en returns
    if (!en) begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
    end
  end

  assign rf_we      = we_raw & en;
  assign mem_addr   = pc_q;
  assign rf_raddr_a = ir_q[4:3];
  assign rf_raddr_b = ir_q[2:1];
  assign rf_waddr   = ir_q[4:3];
  assign halted     = (state_q == HALT);

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous active-high reset, rst; all state SHALL change only on the rising edge of clk.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  advance enable; 0 = stall
- mem_data  in  8  program memory read data, valid one cycle after mem_addr is presented
- mem_addr  out  8  program memory address (equals pc)
- alu_sel  out  3  operation select to the ALU
- rf_raddr_a  out  2  register-file read port A address
- rf_raddr_b  out  2  register-file read port B address
- rf_waddr  out  2  register-file write address
- rf_we  out  1  register-file write enable
- wb_sel  out  1  write-back source: 0 = ALU result, 1 = imm_data
- imm_data  out  8  immediate operand to the register file
- halted  out  1  processor stopped on HLT

Function
REQ-003 Instruction format SHALL be: ir[7:5] opcode, ir[4:3] rd, ir[2:1] rs, ir[0] ignored.
REQ-004 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MOV, 101 LDI rd,#imm (2 bytes), 110 JMP addr (2 bytes), 111 HLT.
REQ-005 The FSM SHALL have the states FETCH, DECODE, EXEC, OPERAND, IMM and HALT, encoded in 3 bits.
REQ-006 FETCH SHALL drive mem_addr = pc and go to DECODE.
REQ-007 DECODE SHALL load ir <= mem_data and set pc <= pc+1; the next state SHALL be EXEC for opcodes 000-100, OPERAND for 101/110, and HALT for 111.
REQ-008 EXEC SHALL drive alu_sel = ir[7:5], rf_raddr_a = rd, rf_raddr_b = rs, rf_waddr = rd, wb_sel = 0 and rf_we = 1 for exactly one cycle, then go to FETCH.
REQ-009 OPERAND SHALL drive mem_addr = pc and go to IMM.
REQ-010 IMM with LDI SHALL drive imm_data = mem_data, wb_sel = 1, rf_waddr = rd and rf_we = 1, set pc <= pc+1, and go to FETCH.
REQ-011 IMM with JMP SHALL set pc <= mem_data, keep rf_we = 0, and go to FETCH.
REQ-012 HALT SHALL hold halted = 1 and rf_we = 0 and SHALL keep pc constant until rst.
REQ-013 Latency SHALL be 3 cycles for ALU-class instructions, 4 cycles for LDI/JMP, and 2 cycles from fetch until halted is asserted for HLT.
REQ-014 pc arithmetic SHALL be modulo 256 (8'hFF + 1 = 8'h00), with no flag or trap.
REQ-015 When en = 0, state, pc and ir SHALL hold, and rf_we SHALL be forced to 0; the stalled step SHALL execute exactly once after en returns to 1.
REQ-016 Outputs SHALL be decoded from state and ir only; imm_data SHALL be the only output combinationally dependent on mem_data.
REQ-017 Outside EXEC and IMM, the outputs SHALL be alu_sel = 000, rf_we = 0, wb_sel = 0 and imm_data = 8'h00; read and write addresses SHALL still follow ir.
REQ-018 rf_we SHALL never be 1 for two consecutive cycles.

Reset
REQ-019 With rst = 1 at a clock edge, the block SHALL set state = FETCH, pc = 8'h00 and ir = 8'h00, regardless of en or the current state, including mid-instruction and HALT.
REQ-020 The output values after reset SHALL be: mem_addr = 00, rf_we = 0, wb_sel = 0, alu_sel = 000, imm_data = 00, halted = 0, all register-file addresses = 0.
REQ-021 An instruction interrupted by reset SHALL produce no rf_we pulse, and the first fetch after reset SHALL be from address 00.

Verification
REQ-022 The bench SHALL cover each of the following scenarios (stimulus -> required response):
- Memory {00: A4 (LDI r0), 01: 05} -> rf_we = 1 with wb_sel = 1, imm_data = 05 and rf_waddr = 0 in cycle 4; pc = 02 afterwards.
- Memory {00: 0A (ADD r1,r1)} -> in cycle 3, alu_sel = 000, raddr_a = 1, raddr_b = 1, waddr = 1 and rf_we = 1; next mem_addr = 01.
- Memory {00: C0 (JMP), 01: 10} -> after 4 cycles, mem_addr = 10 with no rf_we pulse; then JMP to FF followed by an ALU-class instruction at FF -> next fetch from 00.
- Memory {00: E0 (HLT)} -> halted = 1 from cycle 3 onward with pc = 01 held; rst then restarts the fetch at 00 with halted = 0.
- LDI sequence with en = 0 for 3 cycles while in IMM -> rf_we stays 0 during the stall, then a single rf_we pulse follows once en = 1.
- rst asserted in OPERAND of an LDI -> no rf_we pulse, and mem_addr = 00 in the next cycle.
